ctrl_seq: RTL
=============

Name: ctrl_seq

Overview:
- Registered successor to the combinational control decoder for the 9-bit accumulator ISA.
- Owns the multi-word instruction state machine (Regular / Target / Immediate / Skip / Halt), the pending-operation register and the compare-flag register internally. The datapath no longer feeds back CurrState or PrevInstruction.
- Sits between the instruction ROM and the PC, ALU, data memory, accumulator/register and LFSR.
- Parametrised in instruction, data, address and PC widths. Adds an instruction-valid stall, a NE branch, a sticky halt and illegal-op detection.

Parameters:
- IW, default 9: instruction width. Must be ≥ 9.
- DW, default 8: data / immediate width. Must be ≤ IW-1.
- AW, default 8: data-memory address width. Must be ≤ IW-1.
- PW, default 9: PC / branch-target width. Must be ≤ IW.

Ports:
- Clk, in, 1: clock, rising edge.
- Reset, in, 1: asynchronous, active-high.
- Instruction, in, IW: current ROM word.
- InstrValid, in, 1: Instruction is valid this cycle.
- ALUFlags, in, 3: {zero, eq, gt} from the ALU.
- PcAdvance, out, 1: PC increments this cycle.
- BranchEn, out, 1: PC loads BranchTarget.
- BranchTarget, out, PW: jump address.
- OPCode, out, 4: ALU operation.
- ALUInput, out, 2: ALU B source. 00 = mem reg, 01 = mem[target], 10 = immediate.
- ImmediateOut, out, DW: immediate operand.
- MemoryTarget, out, AW: direct memory address.
- MemAddrCtrl, out, 1: 1 = MemoryTarget, 0 = mem reg pointer.
- MemValueCtrl, out, 1: 1 = accumulator, 0 = mem reg.
- MemWrEn, out, 1: data-memory write.
- AccLoadEn, out, 1: accumulator load.
- AccClr, out, 1: accumulator clear.
- RegClr, out, 1: mem register clear.
- LFSRSetState, out, 1: LFSR load state.
- LFSRSetTapPtrn, out, 1: LFSR load tap pattern.
- LFSRShift, out, 1: LFSR shift.
- CMPBits, out, 3: registered compare flags.
- State, out, 3: current FSM state, for debug.
- Ack, out, 1: program done (sticky).
- IllegalOp, out, 1: one-cycle pulse on an undefined encoding.

Behaviour:
- Field definitions: B = Instruction[IW-1]; F = Instruction[IW-2:IW-5]; S = Instruction[3:0]; A = Instruction[3:2].
- States: REG=0, TGT=1, IMM=2, SKIP=3, HALT=4. Registers: state, PendOp (4 bits), PendKind (branch / math / store), CMPBits.
- Reset (asynchronous): state=REG, PendOp=0, CMPBits=0.
  - While Reset is high, every output is 0 and State = REG.
- Outputs are combinational from the registered state, Instruction and InstrValid. State updates on the Clk edge only when InstrValid=1.
- InstrValid=0: all strobes are 0 (including PcAdvance) and state holds. This is a stall.
- PcAdvance = InstrValid & ~HALT & ~BranchEn.
- REG, B=1 (branch). Conditions by F:
  - 1000: always.
  - 1001: zero.
  - 1010: gt.
  - 1011: gt|eq.
  - 1100: ~gt.
  - 1101: ~gt|eq.
  - 1110: eq.
  - 1111: ~eq.
  - 0xxx: illegal.
  - All conditions are evaluated on CMPBits (the registered flags, not ALUFlags).
  - Condition true -> TGT with PendKind = branch. Condition false -> SKIP.
- REG, B=0, F=0 (misc ops, by S):
  - 0000: NOP.
  - 0001: AccClr.
  - 0010: RegClr.
  - 0011: LFSRSetState.
  - 0100: LFSRSetTapPtrn.
  - 0101: LFSRShift.
  - 1000: CMP. CMPBits <= ALUFlags at the clock edge.
  - 1100: STR direct -> TGT with PendKind = store.
  - 1110: store via pointer. MemWrEn=1, MemAddrCtrl=0, MemValueCtrl=1.
  - 1111: Ack=1 -> HALT.
  - Any other S: IllegalOp.
- REG, B=0, F≠0 (math, OPCode=F). By A:
  - 00: AccLoadEn=1, ALUInput=00, single word.
  - 01: PendOp <= F, PendKind = math, -> TGT. No strobes this cycle.
  - 10: PendOp <= F -> IMM. No strobes this cycle.
  - 11: IllegalOp, stay in REG.
- TGT (second word is the operand; always returns to REG):
  - PendKind = branch: BranchEn=1, BranchTarget = Instruction[PW-1:0].
  - PendKind = math: OPCode=PendOp, ALUInput=01, MemAddrCtrl=1, MemoryTarget = Instruction[AW-1:0], AccLoadEn=1.
  - PendKind = store: MemWrEn=1, MemAddrCtrl=1, MemValueCtrl=1, MemoryTarget = Instruction[AW-1:0].
- IMM: OPCode=PendOp, ALUInput=10, ImmediateOut = Instruction[DW-1:0], AccLoadEn=1 -> REG.
- SKIP: no strobes except PcAdvance. The operand word is discarded -> REG.
- HALT: Ack=1 every cycle, all other strobes 0, PcAdvance=0. Leaves HALT only on Reset.
- Undecoded strobe outputs default to 0.
- MemoryTarget and ImmediateOut are always driven from the low bits of Instruction.
- Reset asserted mid-sequence (TGT/IMM/SKIP) abandons the pending operation; the next word is decoded in REG.
- IllegalOp is a single-cycle pulse (only while InstrValid=1). Execution continues.

Test Plan:
- Reset, then CMP with ALUFlags=3'b011, then branch F=1010 (gt), then operand word 9'h05A -> CMPBits=011, State goes REG→TGT, next cycle BranchEn=1 with BranchTarget=0x05A, then State=REG.
- CMPBits=000, branch F=1110 (eq), then word 0x1FF -> SKIP, no BranchEn, PcAdvance=1 on both cycles.
- Math F=0011 with A=10, InstrValid low for 3 cycles, then word 0x07 -> state held in IMM during the stall with no strobes; then OPCode=3, ALUInput=10, ImmediateOut=0x07, AccLoadEn=1.
- STR direct, then word 0x2C -> MemWrEn=1, MemAddrCtrl=1, MemValueCtrl=1, MemoryTarget=0x2C.
- Done (S=1111) -> Ack=1, PcAdvance=0, held for 10 cycles. Reset releases: Ack=0, State=REG.
- Math A=11 -> IllegalOp pulses for 1 cycle, state stays REG. Reset asserted while in TGT -> the following word is decoded as a REG instruction.

Source files
------------

// File: rtl/ctrl_seq.sv
// Registered control sequencer for the 9-bit accumulator ISA: multi-word instruction FSM,
// pending-op and compare-flag registers, with stall, sticky halt and illegal-op detection.
//
// state | meaning
// ------+-----------------------------------------------------------
// REG   | decode a single-word or first word of a multi-word instr
// TGT   | word is an address operand (branch / math / store)
// IMM   | word is an immediate operand for the pending math op
// SKIP  | operand of a not-taken branch, discarded
// HALT  | program done, Ack held until Reset
module ctrl_seq #(
  parameter int IW = 9,
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int PW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [IW-1:0] Instruction,
  input  logic          InstrValid,
  input  logic [2:0]    ALUFlags,
  output logic          PcAdvance,
  output logic          BranchEn,
  output logic [PW-1:0] BranchTarget,
  output logic [3:0]    OPCode,
  output logic [1:0]    ALUInput,
  output logic [DW-1:0] ImmediateOut,
  output logic [AW-1:0] MemoryTarget,
  output logic          MemAddrCtrl,
  output logic          MemValueCtrl,
  output logic          MemWrEn,
  output logic          AccLoadEn,
  output logic          AccClr,
  output logic          RegClr,
  output logic          LFSRSetState,
  output logic          LFSRSetTapPtrn,
  output logic          LFSRShift,
  output logic [2:0]    CMPBits,
  output logic [2:0]    State,
  output logic          Ack,
  output logic          IllegalOp
);

  typedef enum logic [2:0] {
    S_REG  = 3'd0,
    S_TGT  = 3'd1,
    S_IMM  = 3'd2,
    S_SKIP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_BRANCH = 2'd0,
    K_MATH   = 2'd1,
    K_STORE  = 2'd2
  } kind_t;

  state_t     state, state_nxt;
  kind_t      pend_kind, pend_kind_nxt;
  logic [3:0] pend_op, pend_op_nxt;
  logic [2:0] cmp_bits;
  logic       cmp_load;

  logic       fld_b;
  logic [3:0] fld_f;
  logic [3:0] fld_s;
  logic [1:0] fld_a;
  logic       taken;

  assign fld_b = Instruction[IW-1];
  assign fld_f = Instruction[IW-2 -: 4];
  assign fld_s = Instruction[3:0];
  assign fld_a = Instruction[3:2];

  // Flags are {zero, eq, gt}; branches test the registered copy from the last CMP.
  always_comb begin
    taken = 1'b0;
    case (fld_f[2:0])
      3'b000:  taken = 1'b1;
      3'b001:  taken = cmp_bits[2];
      3'b010:  taken = cmp_bits[0];
      3'b011:  taken = cmp_bits[0] | cmp_bits[1];
      3'b100:  taken = ~cmp_bits[0];
      3'b101:  taken = ~cmp_bits[0] | cmp_bits[1];
      3'b110:  taken = cmp_bits[1];
      default: taken = ~cmp_bits[1];
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_REG;
      pend_op   <= 4'd0;
      pend_kind <= K_BRANCH;
      cmp_bits  <= 3'd0;
    end else if (InstrValid) begin
      state     <= state_nxt;
      pend_op   <= pend_op_nxt;
      pend_kind <= pend_kind_nxt;
      if (cmp_load) cmp_bits <= ALUFlags;
    end
  end

  always_comb begin
    state_nxt      = state;
    pend_op_nxt    = pend_op;
    pend_kind_nxt  = pend_kind;
    cmp_load       = 1'b0;
    PcAdvance      = 1'b0;
    BranchEn       = 1'b0;
    BranchTarget   = '0;
    OPCode         = 4'd0;
    ALUInput       = 2'b00;
    ImmediateOut   = Instruction[DW-1:0];
    MemoryTarget   = Instruction[AW-1:0];
    MemAddrCtrl    = 1'b0;
    MemValueCtrl   = 1'b0;
    MemWrEn        = 1'b0;
    AccLoadEn      = 1'b0;
    AccClr         = 1'b0;
    RegClr         = 1'b0;
    LFSRSetState   = 1'b0;
    LFSRSetTapPtrn = 1'b0;
    LFSRShift      = 1'b0;
    Ack            = 1'b0;
    IllegalOp      = 1'b0;

    case (state)
      S_REG: begin
        if (fld_b) begin
          if (fld_f[3]) begin
            pend_kind_nxt = K_BRANCH;
            state_nxt     = taken ? S_TGT : S_SKIP;
          end else begin
            IllegalOp = 1'b1;
          end
        end else if (fld_f == 4'd0) begin
          case (fld_s)
            4'b0000: ;
            4'b0001: AccClr         = 1'b1;
            4'b0010: RegClr         = 1'b1;
            4'b0011: LFSRSetState   = 1'b1;
            4'b0100: LFSRSetTapPtrn = 1'b1;
            4'b0101: LFSRShift      = 1'b1;
            4'b1000: cmp_load       = 1'b1;
            4'b1100: begin
              pend_kind_nxt = K_STORE;
              state_nxt     = S_TGT;
            end
            4'b1110: begin
              MemWrEn      = 1'b1;
              MemValueCtrl = 1'b1;
            end
            4'b1111: begin
              Ack       = 1'b1;
              state_nxt = S_HALT;
            end
            default: IllegalOp = 1'b1;
          endcase
        end else begin
          OPCode = fld_f;
          case (fld_a)
            2'b00: AccLoadEn = 1'b1;
            2'b01: begin
              pend_op_nxt   = fld_f;
              pend_kind_nxt = K_MATH;
              state_nxt     = S_TGT;
            end
            2'b10: begin
              pend_op_nxt = fld_f;
              state_nxt   = S_IMM;
            end
            default: IllegalOp = 1'b1;
          endcase
        end
      end
      S_TGT: begin
        state_nxt = S_REG;
        case (pend_kind)
          K_BRANCH: begin
            BranchEn     = 1'b1;
            BranchTarget = Instruction[PW-1:0];
          end
          K_MATH: begin
            OPCode      = pend_op;
            ALUInput    = 2'b01;
            MemAddrCtrl = 1'b1;
            AccLoadEn   = 1'b1;
          end
          default: begin
            MemWrEn      = 1'b1;
            MemAddrCtrl  = 1'b1;
            MemValueCtrl = 1'b1;
          end
        endcase
      end
      S_IMM: begin
        OPCode    = pend_op;
        ALUInput  = 2'b10;
        AccLoadEn = 1'b1;
        state_nxt = S_REG;
      end
      S_SKIP: state_nxt = S_REG;
      default: begin
        Ack       = 1'b1;
        state_nxt = S_HALT;
      end
    endcase

    PcAdvance = InstrValid & (state != S_HALT) & ~BranchEn;

    // A stall suppresses every strobe; Ack survives only as the sticky HALT indication.
    if (!InstrValid) begin
      BranchEn       = 1'b0;
      MemWrEn        = 1'b0;
      AccLoadEn      = 1'b0;
      AccClr         = 1'b0;
      RegClr         = 1'b0;
      LFSRSetState   = 1'b0;
      LFSRSetTapPtrn = 1'b0;
      LFSRShift      = 1'b0;
      IllegalOp      = 1'b0;
      Ack            = (state == S_HALT);
    end

    if (Reset) begin
      PcAdvance      = 1'b0;
      BranchEn       = 1'b0;
      BranchTarget   = '0;
      OPCode         = 4'd0;
      ALUInput       = 2'b00;
      ImmediateOut   = '0;
      MemoryTarget   = '0;
      MemAddrCtrl    = 1'b0;
      MemValueCtrl   = 1'b0;
      MemWrEn        = 1'b0;
      AccLoadEn      = 1'b0;
      AccClr         = 1'b0;
      RegClr         = 1'b0;
      LFSRSetState   = 1'b0;
      LFSRSetTapPtrn = 1'b0;
      LFSRShift      = 1'b0;
      Ack            = 1'b0;
      IllegalOp      = 1'b0;
    end
  end

  assign State   = state;
  assign CMPBits = cmp_bits;

endmodule
